// File: rtl/fp_normalize.sv
// Post-addition normalizer: turns the adder's raw sign/exponent/mantissa sum into a
// packed single-precision word, shifting left one bit per cycle on cancellation.
module fp_normalize #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_zero,
    output logic              out_overflow
);

    localparam int FRAC_W = MANT_W - 2;
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_SAT = EXP_MAX - EXP_ONE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                sign_r, sign_s;
    logic [EXP_W-1:0]    exp_r, exp_s;
    logic [MANT_W-1:0]   mant_r, mant_s;
    logic [31:0]         result_r, result_s;
    logic                zero_r, zero_s;
    logic                ovf_r, ovf_s;

    function automatic logic [31:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                         input logic [FRAC_W-1:0] f);
        pack = {s, e, f};
    endfunction

    // Next-state and datapath: one normalization decision per NORM cycle, in priority order.
    always_comb begin
        state_s  = state_r;
        sign_s   = sign_r;
        exp_s    = exp_r;
        mant_s   = mant_r;
        result_s = result_r;
        zero_s   = zero_r;
        ovf_s    = ovf_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = NORM;
                    sign_s  = in_sign;
                    exp_s   = in_exp;
                    mant_s  = in_mant;
                end else begin
                    state_s = IDLE;
                end
            end
            NORM: begin
                state_s = DONE;
                zero_s  = 1'b0;
                ovf_s   = 1'b0;
                // exp stays below all-ones in NORM unless it arrived that way (NaN/inf).
                if (exp_r == EXP_MAX) begin
                    result_s = pack(sign_r, EXP_MAX, mant_r[FRAC_W-1:0]);
                end else if (mant_r == {MANT_W{1'b0}}) begin
                    result_s = 32'h0000_0000;
                    zero_s   = 1'b1;
                end else if (mant_r[MANT_W-1]) begin
                    if (exp_r == EXP_SAT) begin
                        result_s = pack(sign_r, EXP_MAX, {FRAC_W{1'b0}});
                        ovf_s    = 1'b1;
                    end else begin
                        exp_s    = exp_r + EXP_ONE;
                        mant_s   = mant_r >> 1'b1;
                        result_s = pack(sign_r, exp_r + EXP_ONE, mant_r[FRAC_W:1]);
                    end
                end else if (mant_r[MANT_W-2]) begin
                    result_s = pack(sign_r, exp_r, mant_r[FRAC_W-1:0]);
                end else if (exp_r <= EXP_ONE) begin
                    result_s = {sign_r, 31'h0000_0000};
                    zero_s   = 1'b1;
                end else begin
                    state_s = NORM;
                    mant_s  = mant_r << 1'b1;
                    exp_s   = exp_r - EXP_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and working/result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            sign_r   <= 1'b0;
            exp_r    <= {EXP_W{1'b0}};
            mant_r   <= {MANT_W{1'b0}};
            result_r <= 32'h0000_0000;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            sign_r   <= sign_s;
            exp_r    <= exp_s;
            mant_r   <= mant_s;
            result_r <= result_s;
            zero_r   <= zero_s;
            ovf_r    <= ovf_s;
        end
    end

    assign in_ready     = (state_r == IDLE) && reset;
    assign out_valid    = (state_r == DONE);
    assign out_result   = result_r;
    assign out_zero     = zero_r;
    assign out_overflow = ovf_r;

endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: directed plan vectors plus randomized operands
// checked against a closed-form reference model of the normalization rules.
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [31:0] r;
        logic        z;
        logic        o;
        int          lat;
    } vec_t;

    vec_t dir [10];

    always #5 clk = ~clk;

    fp_normalize #(.EXP_W(8), .MANT_W(25)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference: find the leading one, count needed shifts, compare with exponent headroom.
    function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                  output logic [31:0] r, output logic z, output logic o,
                                  output int lat);
        int p;
        int k;
        int ei;
        logic [24:0] t;
        r = 32'h0; z = 1'b0; o = 1'b0; lat = 1;
        ei = int'(e);
        if (e == 8'hFF) begin
            r = {s, 8'hFF, m[22:0]};
        end else if (m == 25'd0) begin
            z = 1'b1;
        end else if (m >= 25'h1000000) begin
            if (e == 8'hFE) begin
                r = {s, 8'hFF, 23'd0};
                o = 1'b1;
            end else begin
                t = m / 25'd2;
                r = {s, 8'(ei + 1), t[22:0]};
            end
        end else begin
            p = 0;
            for (int b = 0; b < 24; b++) if (m[b]) p = b;
            k = 23 - p;
            if (k == 0 || ei >= k + 1) begin
                t = m * (25'd1 << k);
                r = {s, 8'(ei - k), t[22:0]};
                lat = k + 1;
            end else begin
                r = {s, 31'd0};
                z = 1'b1;
                lat = (ei > 1) ? ei : 1;
            end
        end
    endfunction

    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                          input logic [31:0] wr, input logic wz, input logic wo,
                          input int wlat, input int hold);
        int lat;
        int guard;
        logic busy_err;
        logic hold_err;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("in_ready_idle", in_ready, 1'b1);
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mant  = 25'($urandom());
        lat = 0;
        busy_err = 1'b0;
        while (lat < 40) begin
            if (in_ready) busy_err = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check_eq("latency", lat, wlat);
        check_eq("busy_in_ready", busy_err, 1'b0);
        if (!out_valid) begin
            $display("FAIL timeout: got no out_valid, expected within %0d cycles", wlat);
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            return;
        end
        check_eq("result", out_result, wr);
        check_eq("zero", out_zero, wz);
        check_eq("overflow", out_overflow, wo);
        hold_err = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || out_result !== wr) hold_err = 1'b1;
        end
        if (hold > 0) check_eq("hold_stable", hold_err, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("single_transfer", out_valid, 1'b0);
    endtask

    initial begin
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [24:0] rnd;
        logic [31:0] r;
        logic        z;
        logic        o;
        int          lat;
        int          p;
        int          sel;

        dir[0] = '{1'b0, 8'h7F, 25'h0800000, 32'h3F80_0000, 1'b0, 1'b0, 1};
        dir[1] = '{1'b0, 8'h7F, 25'h1000000, 32'h4000_0000, 1'b0, 1'b0, 1};
        dir[2] = '{1'b0, 8'h7F, 25'h0000001, 32'h3400_0000, 1'b0, 1'b0, 24};
        dir[3] = '{1'b1, 8'h7F, 25'h0000000, 32'h0000_0000, 1'b1, 1'b0, 1};
        dir[4] = '{1'b1, 8'h02, 25'h0000001, 32'h8000_0000, 1'b1, 1'b0, 2};
        dir[5] = '{1'b1, 8'hFE, 25'h1000000, 32'hFF80_0000, 1'b0, 1'b1, 1};
        dir[6] = '{1'b0, 8'hFF, 25'h0C00001, 32'h7FC0_0001, 1'b0, 1'b0, 1};
        dir[7] = '{1'b0, 8'hFD, 25'h1000001, 32'h7F00_0000, 1'b0, 1'b0, 1};
        dir[8] = '{1'b0, 8'h01, 25'h0400000, 32'h0000_0000, 1'b1, 1'b0, 1};
        dir[9] = '{1'b1, 8'h00, 25'h0000005, 32'h8000_0000, 1'b1, 1'b0, 1};

        reset = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h00;
        in_mant = 25'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_result", out_result, 32'h0);
        check_eq("rst_out_zero", out_zero, 1'b0);
        check_eq("rst_out_overflow", out_overflow, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        #1;

        for (int i = 0; i < 10; i++) begin
            run_op(dir[i].s, dir[i].e, dir[i].m, dir[i].r, dir[i].z, dir[i].o,
                   dir[i].lat, (i == 0) ? 5 : i % 3);
        end

        // Reset asserted during the 10th NORM cycle of a long cancellation.
        in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("mid_norm_valid", out_valid, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_out_result", out_result, 32'h0);
        check_eq("mid_rst_out_zero", out_zero, 1'b0);
        check_eq("mid_rst_out_overflow", out_overflow, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        run_op(1'b0, 8'h7F, 25'h0800000, 32'h3F80_0000, 1'b0, 1'b0, 1, 0);

        for (int i = 0; i < 300; i++) begin
            s   = 1'($urandom());
            sel = $urandom_range(0, 9);
            if (sel < 2)      e = 8'hFF;
            else if (sel == 2) e = 8'hFE;
            else if (sel < 6)  e = 8'($urandom_range(0, 26));
            else               e = 8'($urandom());
            p   = $urandom_range(0, 25);
            rnd = 25'($urandom());
            if (p == 25) m = 25'd0;
            else         m = (25'd1 << p) | (rnd & ((25'd1 << p) - 25'd1));
            model(s, e, m, r, z, o, lat);
            run_op(s, e, m, r, z, o, lat, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_normalize.md
# fp_normalize

Multi-cycle post-addition normalizer for the single-precision FP datapath. It sits directly downstream of the FP adder's raw sign/exponent/mantissa sum and produces a packed IEEE-754 single-precision word. It handles carry-out right shift, left shift on cancellation (one bit per cycle), zero, overflow to infinity, and underflow flush-to-zero. It uses valid/ready handshakes on both sides so the adder result can be registered and held while normalization iterates.

## Interface
- `EXP_W`, 8, exponent width; fixed for single precision.
- `MANT_W`, 25, raw mantissa width: bit 24 is carry-out, bit 23 is the hidden one, bits 22:0 are the fraction.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  raw sum present.
- `in_ready`  out  1  block can accept; combinational, equals (state==IDLE) and reset high.
- `in_sign`  in  1  sign of the raw sum.
- `in_exp`  in  EXP_W  biased exponent of the raw sum.
- `in_mant`  in  MANT_W  unnormalized magnitude.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  32  packed {sign, exp[7:0], frac[22:0]}.
- `out_zero`  out  1  result is a (possibly flushed) zero.
- `out_overflow`  out  1  exponent saturated to infinity.

## Operation
- States: IDLE, NORM, DONE.
- **IDLE:** `in_ready`=1. On `in_valid`&`in_ready`, capture sign/exp/mant into working registers and go to NORM.
- **NORM:** evaluated each cycle in the priority order below. Items 1–6 go to DONE at that edge; item 7 stays in NORM.
  1. `in_exp`==8'hFF at capture: pass through {sign, 8'hFF, mant[22:0]}; both flags 0.
  2. mant==0: result 32'h0000_0000; `out_zero`=1.
  3. mant[24]=1 and exp==8'hFE: result {sign, 8'hFF, 23'b0}; `out_overflow`=1.
  4. mant[24]=1: mant>>=1, exp+=1; the dropped bit is truncated (no rounding).
  5. mant[23]=1: already normalized.
  6. exp<=1: underflow; result {sign, 31'b0}; `out_zero`=1. No denormals are produced. An input with exp==0 and nonzero mantissa lands here on its first NORM cycle.
  7. Otherwise: mant<<=1, exp-=1; stay in NORM.
- **DONE:** `out_valid`=1.
  - `out_result` and both flags are held stable until `out_ready`=1.
  - On `out_ready`, go to IDLE at the next edge.
- No accept occurs in DONE or NORM (`in_ready`=0).
- Width rules: exp arithmetic is 8-bit unsigned. Underflow and overflow checks make wrap impossible. Left shifts are bounded at 23 by mant≠0.

## Timing
- **Reset values while reset is low, applied at the edge:** state=IDLE, `out_valid`=0, `out_result`=32'h0, `out_zero`=0, `out_overflow`=0, `in_ready`=0.
- **Reset mid-operation (NORM or DONE):** the in-flight result is discarded. `out_valid` is 0 after the first edge with reset low. `in_ready` returns to 1 in the first cycle after reset goes high.
- **Latency:** accept at edge E0. `out_valid` is visible after edge E0+k+1, where k is the number of left shifts (0–23). Latency is 1 cycle for the carry, normalized, zero, overflow and NaN/inf cases, and at most 24 cycles.
- **Throughput:** one result per k+3 cycles when `out_ready` is held high (the DONE→IDLE→accept sequence costs 2 edges).
- **Output handshake:** a transfer occurs on an edge where `out_valid`&`out_ready`. `out_ready` has no effect outside DONE.
- **Input handshake:** `in_valid` is ignored while `in_ready`=0. Inputs only need to be stable at the accepting edge.

## Test plan
- **Normalized input:** sign 0, exp 8'h7F, mant 25'h0800000 → `out_result` 32'h3F80_0000 one cycle after accept; flags 0.
- **Carry-out:** exp 8'h7F, mant 25'h1000000 → 32'h4000_0000, latency 1.
- **Massive cancellation:** exp 8'h7F, mant 25'h0000001 → 32'h3400_0000 after 24 cycles. `in_ready` is 0 throughout.
- **Zero and underflow:**
  - mant 0, sign 1 → 32'h0000_0000 with `out_zero`=1.
  - sign 1, exp 8'h02, mant 25'h0000001 → 32'h8000_0000 with `out_zero`=1, latency 2.
- **Overflow and passthrough:**
  - sign 1, exp 8'hFE, mant 25'h1000000 → 32'hFF80_0000 with `out_overflow`=1.
  - exp 8'hFF, mant 25'h0C00001 → 32'h7FC0_0001.
- **Backpressure and reset:**
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_result` is stable and `out_valid` stays 1; the release transfers exactly once.
  - Drive reset low during the 10th NORM cycle → all outputs return to their reset values at the next edge, and the next input is accepted normally.
